// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/load_store_aligner.sv
// Combinational lane steering for loads and stores: byte enables, shifted
// write data, formatted load data, and the misaligned / illegal decode.
module load_store_aligner
  import mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] dmem_readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] lane_data;

  // Decode width: enables, alignment check, and unsupported width codes.
  always_comb begin
    byteenable = 4'b0000;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (func3)
      F3_B, F3_BU: byteenable = BE_BYTE << offset;
      F3_H, F3_HU: begin
        byteenable = BE_HALF << offset;
        misaligned = offset[0];
      end
      F3_W: begin
        byteenable = BE_WORD;
        misaligned = |offset;
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned widths exist only for loads.
    if (is_store && ((func3 == F3_BU) || (func3 == F3_HU))) begin
      illegal = 1'b1;
    end
    if (illegal) begin
      byteenable = 4'b0000;
      misaligned = 1'b0;
    end
  end

  assign write_data = store_data << {offset, 3'b000};
  assign lane_data  = dmem_readdata >> {offset, 3'b000};

  // Select the addressed byte/half and extend it to 32 bits.
  always_comb begin
    load_data = 32'h0000_0000;
    case (func3)
      F3_B:    load_data = {{24{lane_data[7]}}, lane_data[7:0]};
      F3_H:    load_data = {{16{lane_data[15]}}, lane_data[15:0]};
      F3_W:    load_data = dmem_readdata;
      F3_BU:   load_data = {24'h000000, lane_data[7:0]};
      F3_HU:   load_data = {16'h0000, lane_data[15:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// MEM stage: one data-cache transaction per load/store with a
// request/busywait handshake, pipeline stall and a wait timeout.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [31:0] dmem_readdata,
  input  logic        dmem_busywait,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_writedata,
  output logic [3:0]  dmem_byteenable,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        illegal_op,
  output logic        timeout_err
);

  localparam bit             TIMEOUT_EN = (MAX_WAIT != 0);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t           state_q, state_d;
  logic [2:0]       func3_q;
  logic [1:0]       offset_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_op;
  logic             launch;
  logic             timeout_hit;
  logic             in_idle;
  logic [2:0]       al_func3;
  logic [1:0]       al_offset;
  logic [3:0]       al_byteenable;
  logic [31:0]      al_write_data;
  logic [31:0]      al_load_data;
  logic             al_misaligned;
  logic             al_illegal;

  // Reset also masks the live decode so every output reads 0 while held.
  assign mem_op  = RESET & valid_in & (mem_read | mem_write);
  assign in_idle = (state_q == IDLE);

  // In IDLE the aligner decodes the live instruction; afterwards it works
  // from the latched width and offset so upstream changes cannot leak in.
  assign al_func3  = in_idle ? func3 : func3_q;
  assign al_offset = in_idle ? address[1:0] : offset_q;

  assign timeout_hit = TIMEOUT_EN && dmem_busywait && (wait_cnt == WAIT_LAST);

  load_store_aligner u_aligner (
    .func3         (al_func3),
    .offset        (al_offset),
    .is_store      (mem_write),
    .store_data    (store_data),
    .dmem_readdata (dmem_readdata),
    .byteenable    (al_byteenable),
    .write_data    (al_write_data),
    .load_data     (al_load_data),
    .misaligned    (al_misaligned),
    .illegal       (al_illegal)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the combinational stall and error pulses.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    misaligned = 1'b0;
    illegal_op = 1'b0;
    launch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if ((mem_read && mem_write) || al_illegal) begin
            illegal_op = 1'b1;
          end else if (al_misaligned) begin
            misaligned = 1'b1;
          end else begin
            stall   = 1'b1;
            launch  = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (!dmem_busywait || timeout_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request registers, wait counter and the registered load result.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dmem_read       <= 1'b0;
      dmem_write      <= 1'b0;
      dmem_address    <= 32'h0000_0000;
      dmem_writedata  <= 32'h0000_0000;
      dmem_byteenable <= 4'b0000;
      func3_q         <= 3'b000;
      offset_q        <= 2'b00;
      wait_cnt        <= '0;
      load_data       <= 32'h0000_0000;
      timeout_err     <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            dmem_read       <= mem_read;
            dmem_write      <= mem_write;
            dmem_address    <= {address[31:2], 2'b00};
            dmem_writedata  <= al_write_data;
            dmem_byteenable <= al_byteenable;
            func3_q         <= func3;
            offset_q        <= address[1:0];
            wait_cnt        <= '0;
          end
        end
        ACCESS: begin
          if (!dmem_busywait) begin
            if (dmem_read) load_data <= al_load_data;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
          end else if (timeout_hit) begin
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            timeout_err <= 1'b1;
            load_data   <= 32'h0000_0000;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: a default-timeout instance for the
// main load/store paths and a MAX_WAIT=4 instance for the timeout path.
module tb_memory_access_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        valid_in = 1'b0, valid_in2 = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] address = 32'h0, store_data = 32'h0, dmem_readdata = 32'h0;
  logic        dmem_busywait = 1'b0, dmem_busywait2 = 1'b0;

  logic        dmem_read, dmem_write, stall, misaligned, illegal_op, timeout_err;
  logic [31:0] dmem_address, dmem_writedata, load_data;
  logic [3:0]  dmem_byteenable;

  logic        dmem_read2, dmem_write2, stall2, misaligned2, illegal_op2, timeout_err2;
  logic [31:0] dmem_address2, dmem_writedata2, load_data2;
  logic [3:0]  dmem_byteenable2;

  int test_count = 0;
  int fail_count = 0;

  int          stall_cycles;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;
  logic        cap_rd, cap_wr;
  int          acc_cycles;

  always #5 CLK = ~CLK;

  memory_access_unit dut (
    .CLK(CLK), .RESET(RESET), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .func3(func3), .address(address), .store_data(store_data),
    .dmem_readdata(dmem_readdata), .dmem_busywait(dmem_busywait),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_writedata(dmem_writedata), .dmem_byteenable(dmem_byteenable),
    .load_data(load_data), .stall(stall), .misaligned(misaligned),
    .illegal_op(illegal_op), .timeout_err(timeout_err)
  );

  memory_access_unit #(.MAX_WAIT(4), .CNT_W(8)) dut_to (
    .CLK(CLK), .RESET(RESET), .valid_in(valid_in2), .mem_read(mem_read),
    .mem_write(mem_write), .func3(func3), .address(address), .store_data(store_data),
    .dmem_readdata(dmem_readdata), .dmem_busywait(dmem_busywait2),
    .dmem_read(dmem_read2), .dmem_write(dmem_write2), .dmem_address(dmem_address2),
    .dmem_writedata(dmem_writedata2), .dmem_byteenable(dmem_byteenable2),
    .load_data(load_data2), .stall(stall2), .misaligned(misaligned2),
    .illegal_op(illegal_op2), .timeout_err(timeout_err2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] sdata);
    valid_in   = v;
    mem_read   = rd;
    mem_write  = wr;
    func3      = f3;
    address    = addr;
    store_data = sdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Runs one launched op on the main instance from its IDLE cycle to DONE,
  // holding busywait for 'busy' ACCESS cycles.
  task automatic runOp(input int busy);
    int n;
    n = 0;
    stall_cycles = 0;
    dmem_busywait = 1'b0;
    if (stall) stall_cycles++;
    tick();
    cap_addr = dmem_address;
    cap_be   = dmem_byteenable;
    cap_wd   = dmem_writedata;
    cap_rd   = dmem_read;
    cap_wr   = dmem_write;
    while (stall && n < 64) begin
      stall_cycles++;
      dmem_busywait = (n < busy);
      n++;
      tick();
    end
    dmem_busywait = 1'b0;
    checkOutput("access_bound", 32'(n < 64), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick(); tick();
    checkOutput("rst_dmem_read", 32'(dmem_read), 32'd0);
    checkOutput("rst_dmem_write", 32'(dmem_write), 32'd0);
    checkOutput("rst_dmem_address", dmem_address, 32'h0);
    checkOutput("rst_byteenable", 32'(dmem_byteenable), 32'h0);
    checkOutput("rst_load_data", load_data, 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    RESET = 1'b1;
    tick();

    // LW 0x100, no busywait
    dmem_readdata = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b1, 1'b0, LW, 32'h100, 32'h0);
    runOp(0);
    checkOutput("lw_stall_cycles", 32'(stall_cycles), 32'd2);
    checkOutput("lw_dmem_read", 32'(cap_rd), 32'd1);
    checkOutput("lw_dmem_address", cap_addr, 32'h100);
    checkOutput("lw_byteenable", 32'(cap_be), 32'hF);
    checkOutput("lw_done_stall", 32'(stall), 32'd0);
    checkOutput("lw_done_read", 32'(dmem_read), 32'd0);
    checkOutput("lw_load_data", load_data, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();

    // LB / LBU at 0x203 with four busywait cycles
    dmem_readdata = 32'h80AA55CC;
    applyStimulus(1'b1, 1'b1, 1'b0, LB, 32'h203, 32'h0);
    runOp(4);
    checkOutput("lb_stall_cycles", 32'(stall_cycles), 32'd6);
    checkOutput("lb_dmem_address", cap_addr, 32'h200);
    checkOutput("lb_byteenable", 32'(cap_be), 32'h8);
    checkOutput("lb_load_data", load_data, 32'hFFFFFF80);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, LBU, 32'h203, 32'h0);
    runOp(4);
    checkOutput("lbu_stall_cycles", 32'(stall_cycles), 32'd6);
    checkOutput("lbu_load_data", load_data, 32'h00000080);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();

    // LH at 0x202 and LHU at 0x200, one busywait cycle
    applyStimulus(1'b1, 1'b1, 1'b0, LH, 32'h202, 32'h0);
    runOp(1);
    checkOutput("lh_stall_cycles", 32'(stall_cycles), 32'd3);
    checkOutput("lh_byteenable", 32'(cap_be), 32'hC);
    checkOutput("lh_load_data", load_data, 32'hFFFF80AA);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, LHU, 32'h200, 32'h0);
    runOp(1);
    checkOutput("lhu_load_data", load_data, 32'h000055CC);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();

    // LBU at 0x203 again so the store below can show load_data is untouched
    applyStimulus(1'b1, 1'b1, 1'b0, LBU, 32'h203, 32'h0);
    runOp(0);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();

    // SH at 0x302
    applyStimulus(1'b1, 1'b0, 1'b1, LH, 32'h302, 32'h1234ABCD);
    runOp(0);
    checkOutput("sh_stall_cycles", 32'(stall_cycles), 32'd2);
    checkOutput("sh_dmem_write", 32'(cap_wr), 32'd1);
    checkOutput("sh_dmem_read", 32'(cap_rd), 32'd0);
    checkOutput("sh_byteenable", 32'(cap_be), 32'hC);
    checkOutput("sh_writedata", cap_wd, 32'hABCD0000);
    checkOutput("sh_dmem_address", cap_addr, 32'h300);
    checkOutput("sh_done_write", 32'(dmem_write), 32'd0);
    checkOutput("sh_load_data_kept", load_data, 32'h00000080);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();

    // SB at 0x101
    applyStimulus(1'b1, 1'b0, 1'b1, LB, 32'h101, 32'h000000A5);
    runOp(0);
    checkOutput("sb_byteenable", 32'(cap_be), 32'h2);
    checkOutput("sb_writedata", cap_wd, 32'h0000A500);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();

    // Misaligned LW 0x101 and SH 0x103
    applyStimulus(1'b1, 1'b1, 1'b0, LW, 32'h101, 32'h0);
    checkOutput("mis_lw_pulse", 32'(misaligned), 32'd1);
    checkOutput("mis_lw_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("mis_lw_no_read", 32'(dmem_read), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    checkOutput("mis_lw_pulse_end", 32'(misaligned), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, LH, 32'h103, 32'h1234ABCD);
    checkOutput("mis_sh_pulse", 32'(misaligned), 32'd1);
    checkOutput("mis_sh_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("mis_sh_no_write", 32'(dmem_write), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();

    // Illegal encodings: load func3 011, store func3 100, read+write both set
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    checkOutput("ill_f3_011", 32'(illegal_op), 32'd1);
    checkOutput("ill_f3_011_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("ill_f3_011_no_read", 32'(dmem_read), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, LBU, 32'h100, 32'h0);
    checkOutput("ill_store_bu", 32'(illegal_op), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, LW, 32'h100, 32'h0);
    checkOutput("ill_rd_wr", 32'(illegal_op), 32'd1);
    tick();
    checkOutput("ill_rd_wr_no_req", 32'({dmem_read, dmem_write}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    checkOutput("ill_pulse_end", 32'(illegal_op), 32'd0);
    tick();

    // Reset asserted mid-ACCESS
    applyStimulus(1'b1, 1'b1, 1'b0, LW, 32'h100, 32'h0);
    dmem_busywait = 1'b1;
    tick();
    checkOutput("rstacc_read_before", 32'(dmem_read), 32'd1);
    checkOutput("rstacc_stall_before", 32'(stall), 32'd1);
    #2 RESET = 1'b0;
    #1;
    checkOutput("rstacc_read_drop", 32'(dmem_read), 32'd0);
    checkOutput("rstacc_stall_drop", 32'(stall), 32'd0);
    checkOutput("rstacc_load_data", load_data, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    dmem_busywait = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    checkOutput("rstacc_idle_stall", 32'(stall), 32'd0);
    checkOutput("rstacc_idle_read", 32'(dmem_read), 32'd0);
    dmem_readdata = 32'h11223344;
    applyStimulus(1'b1, 1'b1, 1'b0, LW, 32'h104, 32'h0);
    runOp(0);
    checkOutput("rstacc_after_stall", 32'(stall_cycles), 32'd2);
    checkOutput("rstacc_after_load", load_data, 32'h11223344);
    applyStimulus(1'b0, 1'b0, 1'b0, LB, 32'h0, 32'h0);
    tick();

    // Timeout instance: first a normal load so load_data is non-zero
    dmem_readdata = 32'hDEADBEEF;
    applyStimulus(1'b0, 1'b1, 1'b0, LW, 32'h100, 32'h0);
    valid_in2 = 1'b1;
    dmem_busywait2 = 1'b0;
    tick();
    tick();
    checkOutput("to_pre_load", load_data2, 32'hDEADBEEF);
    valid_in2 = 1'b0;
    tick();

    // Busywait stuck high
    valid_in2 = 1'b1;
    dmem_busywait2 = 1'b1;
    #1;
    tick();
    acc_cycles = 0;
    for (int n = 0; n < 20 && stall2; n++) begin
      if (dmem_read2) acc_cycles++;
      tick();
    end
    checkOutput("to_access_cycles", 32'(acc_cycles), 32'd4);
    checkOutput("to_err_pulse", 32'(timeout_err2), 32'd1);
    checkOutput("to_load_zero", load_data2, 32'h0);
    checkOutput("to_stall_release", 32'(stall2), 32'd0);
    checkOutput("to_read_drop", 32'(dmem_read2), 32'd0);
    valid_in2 = 1'b0;
    dmem_busywait2 = 1'b0;
    tick();
    checkOutput("to_err_end", 32'(timeout_err2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
